// File: rtl/four_req_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : four_req_rr_arbiter_pkg
// Brief    : Shared constants, state encoding and helpers for the
//            four-requester round-robin mux arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package four_req_rr_arbiter_pkg;

    // Number of requesters and the widths of the index and hold counter
    localparam int c_num_req = 4;
    localparam int c_idx_w   = 2;
    localparam int c_cnt_w   = 4;

    // The pointer starts at 3, so the first search after reset begins at index 0
    localparam logic [c_idx_w-1:0] c_last_rst = 2'd3;

    // Arbiter states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Binary requester index to one-hot grant vector
    function automatic logic [c_num_req-1:0] idx_to_onehot(input logic [c_idx_w-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage : four_req_rr_arbiter_pkg
`default_nettype wire

// File: rtl/four_req_rr_arbiter_rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_picker
// Brief    : Combinational rotating-priority search. It starts at index
//            (last+1) mod 4 and wraps upward. The first set request wins.
//            One index can optionally be excluded from the search.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_picker
    import four_req_rr_arbiter_pkg::*;
(
    input  logic [c_num_req-1:0] req,
    input  logic [c_idx_w-1:0]   last,
    input  logic                 excl_en,
    input  logic [c_idx_w-1:0]   excl_idx,
    output logic [c_idx_w-1:0]   idx,
    output logic                 found
);

    logic [c_idx_w-1:0] w_cand;

    // Walk the four candidates in rotated order and keep the first eligible one
    always_comb begin
        idx    = '0;
        found  = 1'b0;
        w_cand = '0;
        for (int k = 1; k <= c_num_req; k++) begin
            w_cand = last + k[c_idx_w-1:0];
            if (!found && req[w_cand] && !(excl_en && (w_cand == excl_idx))) begin
                idx   = w_cand;
                found = 1'b1;
            end
        end
    end

endmodule : rr_priority_picker
`default_nettype wire

// File: rtl/four_req_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : four_req_rr_arbiter
// Brief    : Round-robin arbiter that drives the select pins of a shared
//            4:1 single-bit mux and a one-hot grant vector. An owner keeps
//            the grant until it drops its request. It is also forced off
//            after MAX_HOLD cycles when another requester is waiting.
// Revision : 1.0 - initial release
// ============================================================================
module four_req_rr_arbiter
    import four_req_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [c_num_req-1:0] req,
    output logic [c_num_req-1:0] grant,
    output logic                 s0,
    output logic                 s1,
    output logic                 busy
);

    localparam logic [c_cnt_w-1:0] c_max_hold = c_cnt_w'(MAX_HOLD);

    arb_state_t             r_state;
    logic [c_idx_w-1:0]     r_last;
    logic [c_cnt_w-1:0]     r_hold_cnt;
    logic [c_num_req-1:0]   r_grant;
    logic [c_idx_w-1:0]     r_sel;

    arb_state_t             w_nxt_state;
    logic [c_idx_w-1:0]     w_nxt_last;
    logic [c_cnt_w-1:0]     w_nxt_hold_cnt;
    logic [c_num_req-1:0]   w_nxt_grant;
    logic [c_idx_w-1:0]     w_nxt_sel;

    logic [c_idx_w-1:0]     w_pick_last;
    logic                   w_pick_excl_en;
    logic [c_idx_w-1:0]     w_pick_idx;
    logic                   w_pick_found;
    logic                   w_others;
    logic                   w_keep;

    // While a grant is active, the search rotates from the current owner and skips it.
    // This covers both the voluntary release and the forced release with one picker.
    // While idle, the search starts from the stored pointer.
    assign w_pick_last    = (r_state == ST_GRANT) ? r_sel : r_last;
    assign w_pick_excl_en = (r_state == ST_GRANT);

    rr_priority_picker u_picker (
        .req      (req),
        .last     (w_pick_last),
        .excl_en  (w_pick_excl_en),
        .excl_idx (r_sel),
        .idx      (w_pick_idx),
        .found    (w_pick_found)
    );

    // Requests other than the current owner, and the decision to keep the grant
    assign w_others = |(req & ~idx_to_onehot(r_sel));
    assign w_keep   = req[r_sel] && ((r_hold_cnt < c_max_hold) || !w_others);

    // State, pointer, counter and output registers; reset clears them asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_last     <= c_last_rst;
            r_hold_cnt <= '0;
            r_grant    <= '0;
            r_sel      <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_last     <= w_nxt_last;
            r_hold_cnt <= w_nxt_hold_cnt;
            r_grant    <= w_nxt_grant;
            r_sel      <= w_nxt_sel;
        end
    end

    // Next-state and next-output decode; the select pins hold their value when idle
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_last     = r_last;
        w_nxt_hold_cnt = r_hold_cnt;
        w_nxt_grant    = r_grant;
        w_nxt_sel      = r_sel;
        case (r_state)
            ST_IDLE: begin
                w_nxt_grant = '0;
                if (w_pick_found) begin
                    w_nxt_state    = ST_GRANT;
                    w_nxt_grant    = idx_to_onehot(w_pick_idx);
                    w_nxt_sel      = w_pick_idx;
                    w_nxt_hold_cnt = c_cnt_w'(1);
                end
            end
            ST_GRANT: begin
                if (w_keep) begin
                    if (r_hold_cnt < c_max_hold) begin
                        w_nxt_hold_cnt = r_hold_cnt + 1'b1;
                    end
                end else begin
                    w_nxt_last = r_sel;
                    if (w_pick_found) begin
                        w_nxt_grant    = idx_to_onehot(w_pick_idx);
                        w_nxt_sel      = w_pick_idx;
                        w_nxt_hold_cnt = c_cnt_w'(1);
                    end else begin
                        w_nxt_state    = ST_IDLE;
                        w_nxt_grant    = '0;
                        w_nxt_hold_cnt = '0;
                    end
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_grant = '0;
            end
        endcase
    end

    assign grant = r_grant;
    assign s0    = r_sel[0];
    assign s1    = r_sel[1];
    assign busy  = (r_state == ST_GRANT);

endmodule : four_req_rr_arbiter
`default_nettype wire

// File: doc/four_req_rr_arbiter.md
Name: four_req_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 single-bit mux between four requesters.
- Drives the mux select lines (s1, s0) and a one-hot grant vector.
- Holds each grant until the owner drops its request, or until a hold limit expires while others are waiting.
- Sits directly in front of one_bit_4_1_mux: mux data inputs a..d come from requesters 0..3, and the mux select pins are driven from this block's s0/s1.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles for one owner while another request is pending; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  4  request lines; bit i = requester i (mux input a,b,c,d for i=0..3)
- grant  output  4  one-hot grant, registered; all zero when idle
- s0  output  1  mux select LSB, registered
- s1  output  1  mux select MSB, registered; {s1,s0} = granted index
- busy  output  1  high while in GRANT state

Behaviour:
- One clock; reset is asynchronous and active-high.
- All outputs and state are registered. While reset is high:
  - grant=4'b0000, s1=0, s0=0, busy=0
  - state=IDLE, last=3 (so requester 0 wins first), hold_cnt=0
- States: IDLE, GRANT.
- Pick function: search req starting at index (last+1) mod 4, ascending with wrap; the first set bit wins. An optional exclude index removes one candidate.
- IDLE:
  - If req != 0: at the next edge enter GRANT, grant=onehot(pick), {s1,s0}=pick, hold_cnt=1, busy=1.
  - Latency from req rising to grant is exactly 1 cycle.
  - If req == 0: remain in IDLE. grant=0, busy=0, and s1/s0 hold their last value (no select toggling while idle).
- GRANT with owner g:
  - req[g]=1 and (hold_cnt<MAX_HOLD or no other req bit set): keep the grant. hold_cnt increments and saturates at MAX_HOLD.
  - req[g]=0: release. Set last=g. If another req bit is set, grant the pick at the next edge, back-to-back with no idle cycle, and reset hold_cnt to 1. Otherwise go to IDLE with grant=0 and busy=0.
  - req[g]=1, hold_cnt==MAX_HOLD, and another req bit set: forced release. Set last=g and grant pick(exclude g) at the next edge with hold_cnt=1.
- Grant is never changed mid-cycle. grant and {s1,s0} always agree whenever grant != 0.
- Exactly zero or one grant bit is high at any time.
- Simultaneous events:
  - Owner drop and a new request in the same cycle: the new request is eligible immediately.
  - Multiple new requests: rotating priority decides.
- A request that rises and falls while another owner holds the grant is not remembered (no request latching).
- Reset mid-grant: outputs clear asynchronously. After deassertion, the next arbitration starts from index 0.
- Fairness bound: a continuously asserted request is granted within 3*MAX_HOLD+1 cycles.

Decomposition:
- Shared constants header:
  - state encoding IDLE=1'b0, GRANT=1'b1
  - index width 2
  - counter width 4
  - reset value of last = 2'd3
- One natural sub-module: rr_priority_picker. It is combinational, with inputs req[3:0], last[1:0], excl_en, excl_idx[1:0] and outputs idx[1:0], found.
- The top level holds the FSM, the last pointer, hold_cnt and the output registers.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> grant=0000, busy=0, {s1,s0}=00 throughout.
- From reset, req=4'b1111 held, MAX_HOLD=8 -> grant 0001 for 8 cycles, then 0010, 0100, 1000, 0001, each for 8 cycles; {s1,s0} = 00,01,10,11; no gap cycles.
- Single requester: req=4'b0100 for 20 cycles, then 0 -> grant=0100 from cycle 1 to cycle 20 (no forced release, hold_cnt saturates); idle next cycle with s1s0=10 held.
- Owner 1 drops req while req[3] rises in the same cycle -> next cycle grant=1000, {s1,s0}=11, busy stays 1.
- Simultaneous req=4'b0101 after last=0 -> grant 0100 first; after it drops, grant 0001.
- Assert reset asynchronously mid-grant (grant=0010) -> grant=0000, s1s0=00, busy=0 without waiting for a clock edge; after release, req=4'b1010 -> grant 0010 first.
